// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver for a shift register's serial output. It assembles WIDTH bits
// MSB- or LSB-first and presents the word with a valid/ack handshake and a sticky overrun flag.
module shift_deserializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             msb_first_i,
    input  logic             shift_en_i,
    input  logic             shift_in_i,
    input  logic             data_ack_i,
    input  logic             clear_err_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             data_valid_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] bit_count_o,
    output logic             overrun_o
);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   sreg_q;
    logic [WIDTH-1:0]   sreg_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               order_q;
    logic [WIDTH-1:0]   data_q;
    logic               valid_q;
    logic               busy_q;
    logic               overrun_q;

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    always_comb begin
        sreg_d = sreg_q;
        if (order_q) begin
            sreg_d = {sreg_q[WIDTH-2:0], shift_in_i};
        end else begin
            sreg_d = {shift_in_i, sreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            sreg_q    <= '0;
            cnt_q     <= '0;
            order_q   <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // A set later in this block overrides the clear on the same edge.
            if (clear_err_i) begin
                overrun_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StCollect;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        sreg_q  <= '0;
                        order_q <= msb_first_i;
                    end
                end
                StCollect: begin
                    if (start_i) begin
                        cnt_q   <= '0;
                        sreg_q  <= '0;
                        order_q <= msb_first_i;
                    end else if (shift_en_i) begin
                        if (cnt_q == LastBit) begin
                            data_q  <= sreg_d;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            sreg_q <= sreg_d;
                            cnt_q  <= cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (data_ack_i) begin
                        valid_q <= 1'b0;
                        if (start_i) begin
                            state_q <= StCollect;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            sreg_q  <= '0;
                            order_q <= msb_first_i;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (start_i || shift_en_i) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_out_o   = data_q;
    assign data_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign bit_count_o  = cnt_q;
    assign overrun_o    = overrun_q;

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receive-side companion to the team's 8-bit universal shift register.
- Samples the serial stream from a shift register's shift_output, one bit per qualified clock.
- Assembles WIDTH bits into a parallel word, MSB-first or LSB-first.
- Presents the word with a valid/ack handshake and flags overrun when a producer outruns the consumer.

Parameters:
- WIDTH, 8, word length in bits (≥2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a frame.
- msb_first  input  1  bit order, sampled only on an accepted start; 1 = first bit lands in the MSB.
- shift_en  input  1  qualifies shift_in this cycle.
- shift_in  input  1  serial data bit.
- data_ack  input  1  consumer accepts data_out.
- clear_err  input  1  synchronous clear of overrun.
- data_out  output  WIDTH  assembled word, held stable while data_valid is high.
- data_valid  output  1  word available.
- busy  output  1  high in COLLECT.
- bit_count  output  CNT_W  bits received in the current frame.
- overrun  output  1  sticky error flag.

Behaviour:
- Reset, asynchronous and active-high, forces the following regardless of clk:
  - state = IDLE, shift register = 0, bit_count = 0.
  - data_out = 0, data_valid = 0, busy = 0, overrun = 0, latched order = MSB-first.
- IDLE:
  - start=1 → COLLECT next cycle; bit_count←0, shift register←0, order←msb_first.
  - A shift_en in the same cycle as an accepted start is not sampled.
  - shift_en without start is ignored and causes no error.
- COLLECT (busy=1):
  - Each cycle with shift_en=1 samples one bit.
    - MSB-first: sreg←{sreg[WIDTH-2:0], shift_in}.
    - LSB-first: sreg←{shift_in, sreg[WIDTH-1:1]}.
    - bit_count increments.
  - shift_en=0 cycles hold all state; gaps of any length are allowed.
  - The WIDTH-th sampled bit causes the following on the same edge:
    - data_out←completed word.
    - data_valid←1 on the next cycle.
    - state←DONE, bit_count←0.
  - Latency is one clock from the last sampled bit to data_valid.
  - start=1 during COLLECT aborts the frame. It restarts as in IDLE (counter and sreg cleared, order relatched) and any shift_en that cycle is discarded. overrun is not set.
- DONE (data_valid=1, busy=0):
  - data_out is frozen.
  - data_ack=1 → data_valid←0 and state←IDLE.
  - data_ack=1 and start=1 in the same cycle → straight to COLLECT, giving back-to-back frames with no idle cycle.
  - start=1 without data_ack: start is ignored and overrun←1.
  - shift_en=1 without data_ack: the bit is dropped and overrun←1.
  - data_ack while not in DONE is ignored.
- overrun:
  - Sticky; cleared only by reset or by clear_err=1.
  - If clear_err and a new overrun event occur in the same cycle, the set wins.
- bit_count always reflects bits sampled so far in COLLECT and is 0 outside COLLECT.
- Reset mid-frame or mid-DONE discards the partial or pending word; no data_valid follows.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset asserted for 3 cycles, then released → all outputs 0, busy=0, data_valid=0.
- MSB-first frame: start with msb_first=1, then 8 consecutive shift_en with bits 0,0,0,1,0,0,1,1 → data_valid rises one cycle after the 8th bit, data_out=8'h13; data_ack → data_valid=0 next cycle.
- LSB-first frame: same bit sequence with msb_first=0, and shift_en gapped (1,0,1,1,0,0,1,…) → data_out=8'hC8, bit_count steps 0..7 only on enabled cycles.
- Abort: start, 5 bits sampled, start again, then 8 bits of 8'hA5 MSB-first → data_out=8'hA5, overrun=0.
- Overrun and back-to-back:
  - Frame completes; without ack, drive shift_en=1 → overrun=1 and data_out unchanged.
  - clear_err → overrun=0.
  - data_ack+start in the same cycle → busy=1 next cycle, and the next frame 8'h3C completes correctly.
- Reset mid-frame after 4 bits → busy=0 and bit_count=0 immediately (asynchronously); no data_valid after release.
